instr_decode_queue: RTL
=======================

// Module: instr_decode_queue
// PURPOSE
//  Parametrised successor to the combinational MIPS field decoder: a DEPTH-entry instruction
//  buffer between IF and ID with valid/ready handshakes, flush and registered field decode.
//  Fetch pushes raw 32-bit words; ID pops fully split fields plus sign/zero-extended imm.
//  Absorbs fetch/decode rate mismatch and gives branch/jump redirect a one-cycle flush.
// PARAMETERS
//  DEPTH  4   entries of storage; power of two, >=2
//  XLEN   32  width of extended immediates imm_sext/imm_zext; >=16
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  rst        in   1         synchronous, active-high reset
//  flush      in   1         synchronous discard of all buffered entries
//  in_valid   in   1         fetch presents in_instr
//  in_ready   out  1         buffer can accept this cycle
//  in_instr   in   32        raw instruction word
//  out_valid  out  1         head entry valid, fields below meaningful
//  out_ready  in   1         ID consumes head this cycle
//  op         out  6         instr[31:26]
//  rs         out  5         instr[25:21]
//  rt         out  5         instr[20:16]
//  rd         out  5         instr[15:11]
//  shamt      out  5         instr[10:6]
//  funct      out  6         instr[5:0]
//  imm        out  16        instr[15:0]
//  imm_sext   out  XLEN      imm sign-extended to XLEN
//  imm_zext   out  XLEN      imm zero-extended to XLEN
//  target     out  26        instr[25:0]
//  count      out  $clog2(DEPTH+1)  entries currently held
// BEHAVIOUR
//  - Circular buffer: wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap DEPTH-1 -> 0), count.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = !flush & (count < DEPTH); no same-cycle push-when-full even if popping.
//  - out_valid = (count != 0). Fields decode combinationally from head storage flop only.
//  - Fields, imm_sext, imm_zext, target are all-zero when out_valid=0 (checkable).
//  - Latency: word pushed at edge N is at the outputs after edge N, out_valid=1 in cycle N+1.
//  - push & pop same cycle (0<count<DEPTH): count unchanged, both pointers advance.
//  - push & pop with count==0: impossible (out_valid=0); push only.
//  - FIFO order strictly preserved; a stalled head (out_ready=0) holds all outputs stable.
//  - flush=1: at next edge count=0, wr_ptr=rd_ptr=0; any push that cycle dropped (in_ready=0).
//    pop in the flush cycle is legal but irrelevant; out_valid=0 from next cycle.
//  - rst=1: same effect as flush, overrides everything; storage contents not cleared.
//  - Reset values: count=0, in_ready=1 (with flush=0), out_valid=0, all fields 0.
//  - Reset mid-stream: entries lost, no spurious out_valid after release.
// CONFIGURATION
//  DECODE_QUEUE_PC_EN defined: adds in_pc[31:0] input, out_pc[31:0] output; pc stored with
//   each entry, out_pc follows head entry, 0 when out_valid=0; pc_plus4 not generated.
//  Undefined: no pc ports or storage; all other behaviour identical.
// TESTING
//  1 rst 2 cycles -> count=0, out_valid=0, in_ready=1, all fields 0.
//  2 push 0x012A4020 -> next cycle out_valid=1, op=0, rs=9, rt=10, rd=8, shamt=0, funct=0x20.
//  3 push 0x8D09FFFC -> op=0x23, rs=8, rt=9, imm=0xFFFC, imm_sext=0xFFFFFFFC,
//    imm_zext=0x0000FFFC; push 0x08000010 -> op=2, target=0x0000010.
//  4 out_ready=0, push 4 words -> count=4, in_ready=0, 5th word not accepted;
//    then out_ready=1 -> words emerge in push order, one per cycle, wrap correct.
//  5 count=2, push+pop same cycle -> count stays 2, head advances to 2nd word.
//  6 count=3, flush=1 with in_valid=1 -> in_ready=0 that cycle; next cycle count=0,
//    out_valid=0; `DECODE_QUEUE_PC_EN: push pc 0x00400008 -> out_pc=0x00400008.

Source files
------------

// File: rtl/instr_decode_queue.sv
// Instruction buffer between fetch and decode: DEPTH-entry circular queue with
// valid/ready handshakes, one-cycle flush and MIPS field decode of the head entry.
// Optional macro DECODE_QUEUE_PC_EN stores a PC with each entry (in_pc/out_pc).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready never depends on in_valid, and out_valid never depends on out_ready.
module instr_decode_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
`ifdef DECODE_QUEUE_PC_EN
  input  logic [31:0]                in_pc,
  output logic [31:0]                out_pc,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [5:0]                 op,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                imm,
  output logic [XLEN-1:0]            imm_sext,
  output logic [XLEN-1:0]            imm_zext,
  output logic [25:0]                target,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          push;
  logic          pop;
  logic [31:0]   head;

  assign in_ready  = !flush && (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is deliberately left uncleared by reset; emptiness is tracked by count.
  always_ff @(posedge clk) begin
    if (push && !rst) instr_mem[wr_ptr] <= in_instr;
  end

  // Gating on out_valid keeps every decoded field at zero while the queue is empty.
  assign head = out_valid ? instr_mem[rd_ptr] : 32'h0;

  always_comb begin
    op       = head[31:26];
    rs       = head[25:21];
    rt       = head[20:16];
    rd       = head[15:11];
    shamt    = head[10:6];
    funct    = head[5:0];
    imm      = head[15:0];
    imm_sext = XLEN'($signed(head[15:0]));
    imm_zext = XLEN'(head[15:0]);
    target   = head[25:0];
  end

`ifdef DECODE_QUEUE_PC_EN
  logic [31:0] pc_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !rst) pc_mem[wr_ptr] <= in_pc;
  end

  assign out_pc = out_valid ? pc_mem[rd_ptr] : 32'h0;
`endif

endmodule
